// File: rtl/secuenciador_raiz_pkg.sv
// Shared constants and types for the square-root peripheral sequencer:
// register map, sequencer states, bus access kinds and access-engine phases.
package pkg_periferico_raiz;

  localparam logic [4:0] DIR_VALOR     = 5'h04;
  localparam logic [4:0] DIR_INICIO    = 5'h0C;
  localparam logic [4:0] DIR_RESULTADO = 5'h10;
  localparam logic [4:0] DIR_ESTADO    = 5'h14;

  localparam int MAX_SONDEOS_DEFECTO = 1024;

  typedef enum logic [2:0] {
    REPOSO,
    ESC_VALOR,
    ESC_INICIO,
    LEE_ESTADO,
    LEE_RESULTADO,
    ESC_PARO,
    ENTREGA
  } estado_t;

  typedef enum logic {
    LECTURA,
    ESCRITURA
  } tipo_acceso_t;

  typedef enum logic [1:0] {
    INACTIVA,
    FASE_A,
    FASE_B
  } fase_t;

endpackage

// File: rtl/secuenciador_raiz_if.sv
// Request/result handshakes plus the peripheral bus of the sequencer.
// The sequencer is the master; the requester/peripheral side is the slave.
interface secuenciador_raiz_if;
  logic        sol_valida;
  logic        sol_lista;
  logic [15:0] sol_operando;
  logic        res_valida;
  logic        res_lista;
  logic [15:0] res_dato;
  logic        res_error;
  logic        bus_habilitar;
  logic [4:0]  bus_direccion;
  logic        bus_leer;
  logic        bus_escribir;
  logic [15:0] bus_salida;
  logic [31:0] bus_entrada;

  modport master (
    input  sol_valida, sol_operando, res_lista, bus_entrada,
    output sol_lista, res_valida, res_dato, res_error,
    output bus_habilitar, bus_direccion, bus_leer, bus_escribir, bus_salida
  );

  modport slave (
    output sol_valida, sol_operando, res_lista, bus_entrada,
    input  sol_lista, res_valida, res_dato, res_error,
    input  bus_habilitar, bus_direccion, bus_leer, bus_escribir, bus_salida
  );
endinterface

// File: rtl/secuenciador_raiz_acceso_bus.sv
// Two-cycle peripheral access engine: one idle cycle to capture the request,
// then phases A and B with all bus outputs registered and held.
module acceso_bus
  import pkg_periferico_raiz::*;
(
  input  logic         i_reloj,
  input  logic         i_reiniciar,
  input  logic         i_ir,
  input  tipo_acceso_t i_tipo,
  input  logic [4:0]   i_direccion,
  input  logic [15:0]  i_dato,
  output logic         o_hecho,
  output logic [15:0]  o_rdato,
  output logic         o_habilitar,
  output logic [4:0]   o_direccion,
  output logic         o_leer,
  output logic         o_escribir,
  output logic [15:0]  o_salida,
  input  logic [31:0]  i_entrada
);

  fase_t       r_fase;
  logic        r_habilitar;
  logic [4:0]  r_direccion;
  logic        r_leer;
  logic        r_escribir;
  logic [15:0] r_salida;
  logic        w_unused_entrada;

  // A request is only captured while idle; clearing at the end of phase B
  // guarantees a zero cycle on the bus before the next access.
  always_ff @(posedge i_reloj) begin
    if (i_reiniciar) begin
      r_fase      <= INACTIVA;
      r_habilitar <= 1'b0;
      r_direccion <= '0;
      r_leer      <= 1'b0;
      r_escribir  <= 1'b0;
      r_salida    <= '0;
    end else begin
      case (r_fase)
        INACTIVA: begin
          if (i_ir) begin
            r_fase      <= FASE_A;
            r_habilitar <= 1'b1;
            r_direccion <= i_direccion;
            r_leer      <= (i_tipo == LECTURA);
            r_escribir  <= (i_tipo == ESCRITURA);
            r_salida    <= (i_tipo == ESCRITURA) ? i_dato : '0;
          end
        end
        FASE_A: r_fase <= FASE_B;
        FASE_B: begin
          r_fase      <= INACTIVA;
          r_habilitar <= 1'b0;
          r_direccion <= '0;
          r_leer      <= 1'b0;
          r_escribir  <= 1'b0;
          r_salida    <= '0;
        end
        default: r_fase <= INACTIVA;
      endcase
    end
  end

  // Done is high during phase B so the caller samples read data on the edge ending it.
  assign o_hecho          = (r_fase == FASE_B);
  assign o_rdato          = i_entrada[15:0];
  assign w_unused_entrada = ^i_entrada[31:16];

  assign o_habilitar = r_habilitar;
  assign o_direccion = r_direccion;
  assign o_leer      = r_leer;
  assign o_escribir  = r_escribir;
  assign o_salida    = r_salida;

endmodule

// File: rtl/secuenciador_raiz.sv
// Square-root peripheral sequencer: operand in, register sequence on the bus, root out.
// Optional SECUENCIADOR_TIMEOUT_EN bounds status polling to MAX_SONDEOS reads.
module secuenciador_raiz
   import pkg_periferico_raiz::*;
#(
   parameter int MAX_SONDEOS = MAX_SONDEOS_DEFECTO
)
(
   input  logic        reloj,
   input  logic        reiniciar,
   input  logic        sol_valida,
   output logic        sol_lista,
   input  logic [15:0] sol_operando,
   output logic        res_valida,
   input  logic        res_lista,
   output logic [15:0] res_dato,
   output logic        res_error,
   output logic        bus_habilitar,
   output logic [4:0]  bus_direccion,
   output logic        bus_leer,
   output logic        bus_escribir,
   output logic [15:0] bus_salida,
   input  logic [31:0] bus_entrada
);

   estado_t      r_estado;
   estado_t      w_siguiente;
   logic [15:0]  r_operando;
   logic [15:0]  r_dato;
   logic         w_ir;
   tipo_acceso_t w_tipo;
   logic [4:0]   w_dir;
   logic [15:0]  w_dato;
   logic         w_hecho;
   logic [15:0]  w_rdato;

`ifdef SECUENCIADOR_TIMEOUT_EN
   localparam int ANCHO_SONDEOS = $clog2(MAX_SONDEOS + 1);
   logic [ANCHO_SONDEOS-1:0] r_sondeos;
   logic                     r_error;
   logic                     w_agotado;

   assign w_agotado = (r_sondeos == ANCHO_SONDEOS'(MAX_SONDEOS - 1));
   assign res_error = r_error;
`else
   assign res_error = 1'b0;
`endif

   // The access engine owns every bus output so they are registered and held per access.
   acceso_bus u_acceso (
      .i_reloj     (reloj),
      .i_reiniciar (reiniciar),
      .i_ir        (w_ir),
      .i_tipo      (w_tipo),
      .i_direccion (w_dir),
      .i_dato      (w_dato),
      .o_hecho     (w_hecho),
      .o_rdato     (w_rdato),
      .o_habilitar (bus_habilitar),
      .o_direccion (bus_direccion),
      .o_leer      (bus_leer),
      .o_escribir  (bus_escribir),
      .o_salida    (bus_salida),
      .i_entrada   (bus_entrada)
   );

   // State register with synchronous reset back to REPOSO.
   always_ff @(posedge reloj) begin
      if (reiniciar) r_estado <= REPOSO;
      else           r_estado <= w_siguiente;
   end

   // Each bus state keeps requesting its access; the engine ignores the request while busy.
   always_comb begin
      w_siguiente = r_estado;
      w_ir        = 1'b0;
      w_tipo      = ESCRITURA;
      w_dir       = '0;
      w_dato      = '0;
      case (r_estado)
         REPOSO: if (sol_valida) w_siguiente = ESC_VALOR;
         ESC_VALOR: begin
            w_ir   = 1'b1;
            w_dir  = DIR_VALOR;
            w_dato = r_operando;
            if (w_hecho) w_siguiente = ESC_INICIO;
         end
         ESC_INICIO: begin
            w_ir   = 1'b1;
            w_dir  = DIR_INICIO;
            w_dato = 16'd1;
            if (w_hecho) w_siguiente = LEE_ESTADO;
         end
         LEE_ESTADO: begin
            w_ir   = 1'b1;
            w_tipo = LECTURA;
            w_dir  = DIR_ESTADO;
            if (w_hecho) begin
               if (w_rdato[0]) w_siguiente = LEE_RESULTADO;
`ifdef SECUENCIADOR_TIMEOUT_EN
               else if (w_agotado) w_siguiente = ESC_PARO;
`endif
            end
         end
         LEE_RESULTADO: begin
            w_ir   = 1'b1;
            w_tipo = LECTURA;
            w_dir  = DIR_RESULTADO;
            if (w_hecho) w_siguiente = ESC_PARO;
         end
         ESC_PARO: begin
            w_ir  = 1'b1;
            w_dir = DIR_INICIO;
            if (w_hecho) w_siguiente = ENTREGA;
         end
         ENTREGA: if (res_lista) w_siguiente = REPOSO;
         default: w_siguiente = REPOSO;
      endcase
   end

   // The result is zeroed at acceptance, so a timed-out run delivers 0 untouched.
   always_ff @(posedge reloj) begin
      if (reiniciar) begin
         r_operando <= '0;
         r_dato     <= '0;
`ifdef SECUENCIADOR_TIMEOUT_EN
         r_sondeos  <= '0;
         r_error    <= 1'b0;
`endif
      end else begin
         if (r_estado == REPOSO && sol_valida) begin
            r_operando <= sol_operando;
            r_dato     <= '0;
`ifdef SECUENCIADOR_TIMEOUT_EN
            r_sondeos  <= '0;
            r_error    <= 1'b0;
`endif
         end
         if (r_estado == LEE_RESULTADO && w_hecho) r_dato <= w_rdato;
`ifdef SECUENCIADOR_TIMEOUT_EN
         if (r_estado == LEE_ESTADO && w_hecho && !w_rdato[0]) begin
            r_sondeos <= r_sondeos + 1'b1;
            if (w_agotado) r_error <= 1'b1;
         end
`endif
      end
   end

   assign sol_lista  = (r_estado == REPOSO);
   assign res_valida = (r_estado == ENTREGA);
   assign res_dato   = r_dato;

endmodule

// File: tb/tb_secuenciador_raiz.sv
// Randomized bench for secuenciador_raiz with a behavioural square-root peripheral
// and a transaction-level model of the expected bus trace and delivery latency.
module tb_secuenciador_raiz;
   import pkg_periferico_raiz::*;

   typedef struct packed {
      logic        esc;
      logic [4:0]  dir;
      logic [15:0] dato;
      logic        rd;
   } acc_t;

`ifdef SECUENCIADOR_TIMEOUT_EN
   localparam int SONDEOS_TB = 4;
`else
   localparam int SONDEOS_TB = 1024;
`endif

   logic reloj = 1'b0;
   logic reiniciar;
   int   nChecks = 0;
   int   nFails = 0;
   int   cyc = 0;

   secuenciador_raiz_if intf();

   // Device under test, wired to the bench's interface bundle port by port.
   secuenciador_raiz #(.MAX_SONDEOS(SONDEOS_TB)) dut (
      .reloj         (reloj),
      .reiniciar     (reiniciar),
      .sol_valida    (intf.sol_valida),
      .sol_lista     (intf.sol_lista),
      .sol_operando  (intf.sol_operando),
      .res_valida    (intf.res_valida),
      .res_lista     (intf.res_lista),
      .res_dato      (intf.res_dato),
      .res_error     (intf.res_error),
      .bus_habilitar (intf.bus_habilitar),
      .bus_direccion (intf.bus_direccion),
      .bus_leer      (intf.bus_leer),
      .bus_escribir  (intf.bus_escribir),
      .bus_salida    (intf.bus_salida),
      .bus_entrada   (intf.bus_entrada)
   );

   always #5 reloj = ~reloj;

   always @(posedge reloj) cyc <= cyc + 1;

   // Behavioural peripheral state
   logic [15:0] pValor = '0;
   logic [15:0] pRaiz = '0;
   logic        pInicio = 1'b0;
   logic        pDone = 1'b0;
   bit          pStuck = 1'b0;
   int          pCuenta = 0;
   int          pLatencia = 5;

   acc_t        traza[$];
   int          runLen = 0;
   logic [23:0] primero;
   bit          skipLen = 1'b0;

   function automatic int isqrt(input int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Peripheral read port: upper bits carry junk that the sequencer must ignore
   always_comb begin
      intf.bus_entrada = '0;
      if (intf.bus_habilitar && intf.bus_leer) begin
         if (intf.bus_direccion == DIR_ESTADO)
            intf.bus_entrada = {16'hDEAD, 15'h0, pDone};
         else if (intf.bus_direccion == DIR_RESULTADO)
            intf.bus_entrada = {16'hBEEF, pRaiz};
      end
   end

   // Peripheral behaviour and bus monitor, evaluated away from the active edge
   initial begin
      acc_t a;
      forever begin
         @(negedge reloj);
         if (reiniciar === 1'b1) begin
            pValor = '0; pRaiz = '0; pInicio = 1'b0; pDone = 1'b0; pCuenta = 0;
         end else if (pInicio && !pDone && !pStuck) begin
            if (pCuenta > 0) pCuenta--;
            if (pCuenta == 0) pDone = 1'b1;
         end
         if (intf.bus_habilitar === 1'b1) begin
            runLen++;
            if (runLen == 1) begin
               primero = {intf.bus_escribir, intf.bus_leer, intf.bus_direccion, intf.bus_salida};
               a.esc  = intf.bus_escribir;
               a.dir  = intf.bus_direccion;
               a.dato = intf.bus_escribir ? intf.bus_salida : 16'h0;
               a.rd   = 1'b0;
               traza.push_back(a);
               if (intf.bus_escribir) begin
                  if (intf.bus_direccion == DIR_VALOR) begin
                     pValor = intf.bus_salida;
                     pRaiz  = 16'(isqrt(int'(intf.bus_salida)));
                  end else if (intf.bus_direccion == DIR_INICIO) begin
                     pDone = 1'b0;
                     pInicio = intf.bus_salida[0];
                     pCuenta = pLatencia;
                  end
               end
            end else begin
               checkOutput("acc_hold",
                           32'({intf.bus_escribir, intf.bus_leer, intf.bus_direccion, intf.bus_salida}),
                           32'(primero));
               if (traza.size() > 0) begin
                  a = traza.pop_back();
                  a.rd = (a.dir == DIR_ESTADO && !a.esc) ? pDone : 1'b0;
                  traza.push_back(a);
               end
            end
         end else begin
            if (runLen != 0 && !skipLen) checkOutput("acc_len", 32'(runLen), 32'd2);
            runLen = 0;
         end
      end
   end

   task automatic expectAcc(input logic esc, input logic [4:0] dir, input logic [15:0] dato,
                            inout int nAcc);
      acc_t a;
      if (traza.size() == 0) begin
         checkOutput("traza_falta", 32'd0, 32'({esc, dir, dato}));
         return;
      end
      a = traza.pop_front();
      nAcc++;
      checkOutput("traza_acc", 32'({a.esc, a.dir, a.dato}), 32'({esc, dir, dato}));
   endtask

   // Expected trace: W04=op, W0C=1, R14 polls, R10 (unless timed out), W0C=0
   task automatic checkTrace(input logic [15:0] op, input logic expErr, input int lat);
      int   nAcc = 0;
      int   nS = 0;
      bit   rds[$];
      acc_t a;
      expectAcc(1'b1, DIR_VALOR, op, nAcc);
      expectAcc(1'b1, DIR_INICIO, 16'd1, nAcc);
      while (traza.size() > 0) begin
         a = traza[0];
         if (a.esc || a.dir != DIR_ESTADO) break;
         a = traza.pop_front();
         rds.push_back(a.rd);
         nAcc++;
         nS++;
      end
      if (expErr) begin
         checkOutput("poll_count", 32'(nS), 32'd4);
         foreach (rds[i]) checkOutput("poll_rd", 32'(rds[i]), 32'd0);
      end else begin
         checkOutput("poll_min", 32'(nS >= 1), 32'd1);
         foreach (rds[i]) checkOutput("poll_rd", 32'(rds[i]), 32'(i == nS - 1));
         expectAcc(1'b0, DIR_RESULTADO, 16'h0, nAcc);
      end
      expectAcc(1'b1, DIR_INICIO, 16'd0, nAcc);
      checkOutput("latencia", 32'(lat), 32'(1 + 3 * nAcc));
      checkOutput("traza_vacia", 32'(traza.size()), 32'd0);
   endtask

   // Called at a falling edge; runs one request through to its delivery handshake
   task automatic applyStimulus(input logic [15:0] op, input logic [15:0] expRaiz,
                                input logic expErr, input int espera,
                                input bit mantener, input logic [15:0] sigOp);
      int c0;
      int k;
      int lat;
      intf.sol_valida   = 1'b1;
      intf.sol_operando = op;
      k = 0;
      while (intf.sol_lista !== 1'b1 && k < 100) begin
         @(negedge reloj);
         k++;
      end
      if (intf.sol_lista !== 1'b1) begin
         checkOutput("sol_lista_espera", 32'(intf.sol_lista), 32'd1);
         intf.sol_valida = 1'b0;
         return;
      end
      c0 = cyc;
      @(negedge reloj);
      if (mantener) intf.sol_operando = sigOp;
      else          intf.sol_valida = 1'b0;
      k = 0;
      while (intf.res_valida !== 1'b1 && k < 500) begin
         @(negedge reloj);
         k++;
      end
      if (intf.res_valida !== 1'b1) begin
         checkOutput("res_valida_espera", 32'(intf.res_valida), 32'd1);
         return;
      end
      lat = cyc - c0;
      checkOutput("res_dato", 32'(intf.res_dato), 32'(expRaiz));
      checkOutput("res_error", 32'(intf.res_error), 32'(expErr));
      for (int i = 0; i < espera; i++) begin
         @(negedge reloj);
         checkOutput("hold_valida", 32'(intf.res_valida), 32'd1);
         checkOutput("hold_dato", 32'(intf.res_dato), 32'(expRaiz));
         checkOutput("hold_error", 32'(intf.res_error), 32'(expErr));
         checkOutput("hold_sol_lista", 32'(intf.sol_lista), 32'd0);
      end
      intf.res_lista = 1'b1;
      @(negedge reloj);
      intf.res_lista = 1'b0;
      checkOutput("sol_lista_sube", 32'(intf.sol_lista), 32'd1);
      checkOutput("res_valida_baja", 32'(intf.res_valida), 32'd0);
      checkTrace(op, expErr, lat);
   endtask

   task automatic checkBusIdle(input string tag);
      checkOutput({tag, "_hab"}, 32'(intf.bus_habilitar), 32'd0);
      checkOutput({tag, "_dir"}, 32'(intf.bus_direccion), 32'd0);
      checkOutput({tag, "_leer"}, 32'(intf.bus_leer), 32'd0);
      checkOutput({tag, "_esc"}, 32'(intf.bus_escribir), 32'd0);
      checkOutput({tag, "_sal"}, 32'(intf.bus_salida), 32'd0);
      checkOutput({tag, "_sol_lista"}, 32'(intf.sol_lista), 32'd1);
      checkOutput({tag, "_res_valida"}, 32'(intf.res_valida), 32'd0);
   endtask

   // Main sequence: reset, directed cases, random cases, optional timeout, mid-run reset.
   initial begin
      logic [15:0] op;
      int k;
      reiniciar         = 1'b1;
      intf.sol_valida   = 1'b0;
      intf.sol_operando = '0;
      intf.res_lista    = 1'b0;
      repeat (3) @(negedge reloj);
      checkBusIdle("reset");
      checkOutput("reset_res_dato", 32'(intf.res_dato), 32'd0);
      checkOutput("reset_res_error", 32'(intf.res_error), 32'd0);
      reiniciar = 1'b0;
      @(negedge reloj);

      pLatencia = 5;
      applyStimulus(16'd144, 16'd12, 1'b0, 0, 1'b0, 16'd0);
      applyStimulus(16'd0, 16'd0, 1'b0, 0, 1'b0, 16'd0);
      applyStimulus(16'd1, 16'd1, 1'b0, 0, 1'b0, 16'd0);
      applyStimulus(16'd65535, 16'd255, 1'b0, 0, 1'b0, 16'd0);
      applyStimulus(16'd400, 16'd20, 1'b0, 20, 1'b0, 16'd0);
      applyStimulus(16'd81, 16'd9, 1'b0, 0, 1'b1, 16'd100);
      applyStimulus(16'd100, 16'd10, 1'b0, 0, 1'b0, 16'd0);

      for (int i = 0; i < 6; i++) begin
         op = 16'($urandom_range(0, 65535));
         pLatencia = int'($urandom_range(1, 9));
         applyStimulus(op, 16'(isqrt(int'(op))), 1'b0, int'($urandom_range(0, 3)), 1'b0, 16'd0);
      end

`ifdef SECUENCIADOR_TIMEOUT_EN
      pStuck = 1'b1;
      applyStimulus(16'd1234, 16'd0, 1'b1, 2, 1'b0, 16'd0);
      pStuck = 1'b0;
`endif

      pLatencia = 6;
      intf.sol_valida   = 1'b1;
      intf.sol_operando = 16'd200;
      @(negedge reloj);
      intf.sol_valida = 1'b0;
      k = 0;
      while (!(intf.bus_habilitar === 1'b1 && intf.bus_leer === 1'b1 &&
               intf.bus_direccion == DIR_ESTADO) && k < 100) begin
         @(negedge reloj);
         k++;
      end
      checkOutput("espera_sondeo", 32'(intf.bus_direccion), 32'(DIR_ESTADO));
      skipLen   = 1'b1;
      reiniciar = 1'b1;
      @(negedge reloj);
      checkBusIdle("reset_medio");
      reiniciar = 1'b0;
      @(negedge reloj);
      traza.delete();
      skipLen = 1'b0;
      applyStimulus(16'd49, 16'd7, 1'b0, 0, 1'b0, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
